// File: rtl/canny_pkg.sv
// Shared definitions for the Canny pipeline stages: edge-class encodings and
// the neighbour tap bundle exchanged between the hysteresis tracker and its line buffer.
package canny_pkg;

    localparam logic [1:0] EDGE_NONE   = 2'b00;
    localparam logic [1:0] EDGE_WEAK   = 2'b01;
    localparam logic [1:0] EDGE_STRONG = 2'b10;
    localparam logic [1:0] EDGE_RSVD   = 2'b11;

    // Keep decisions of the previous row around the current column.
    typedef struct packed {
        logic ul;
        logic up;
        logic ur;
    } nbr_taps_t;

endpackage

// File: rtl/hyst_line_buf.sv
// One-row keep-flag memory for the hysteresis tracker. Presents up-left, up and
// up-right taps for the current column; the up-left value is captured before it is overwritten.
module hyst_line_buf
    import canny_pkg::*;
#(
    parameter int IMG_W = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(IMG_W)-1:0] col,
    input  logic                     wr_bit,
    output nbr_taps_t                taps
);

    localparam int CW = $clog2(IMG_W);

    logic          mem_q [IMG_W];
    logic          ul_q;
    logic          ul_d;
    logic [CW-1:0] col_nxt;

    always_comb begin
        col_nxt = (col == CW'(IMG_W - 1)) ? col : col + CW'(1);
        taps.up = mem_q[col];
        taps.ur = mem_q[col_nxt];
        taps.ul = ul_q;
        // Slot col still holds the previous row here; it becomes up-left for col+1.
        ul_d    = wr_en ? mem_q[col] : ul_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ul_q <= 1'b0;
        else     ul_q <= ul_d;
    end

    // NOTE: the memory has no reset; row-0 masking hides whatever it holds, and leaving it out keeps it RAM-inferable.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[col] <= wr_bit;
    end

endmodule

// File: rtl/hysteresis_tracker_stream.sv
// Streaming single-pass hysteresis stage: turns 2-bit edge classes into final edge
// pixels with valid/ready handshake, frame/line framing and a per-frame edge count.
module hysteresis_tracker_stream
    import canny_pkg::*;
#(
    parameter int IMG_W    = 256,
    parameter int IMG_H    = 256,
    parameter int OUT_W    = 8,
    parameter int CONNECT8 = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic                                s_sof,
    input  logic [1:0]                          s_edge,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [OUT_W-1:0]                    m_pixel,
    output logic                                m_eol,
    output logic                                m_eof,
    output logic [$clog2(IMG_W*IMG_H+1)-1:0]    frame_edges,
    output logic                                frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NW = $clog2(IMG_W * IMG_H + 1);

    logic [CW-1:0]    col_q, col_d, col_cur;
    logic [RW-1:0]    row_q, row_d, row_cur;
    logic [NW-1:0]    run_q, run_d, run_base;
    logic [NW-1:0]    frame_edges_q, frame_edges_d;
    logic             frame_done_q, frame_done_d;
    logic             left_q, left_d;
    logic             m_valid_q, m_valid_d;
    logic [OUT_W-1:0] m_pixel_q, m_pixel_d;
    logic             m_eol_q, m_eol_d;
    logic             m_eof_q, m_eof_d;

    logic      accept;
    logic      first_col, last_col, first_row, last_row;
    logic      nb_left, nb_up, nb_ul, nb_ur, conn, keep;
    nbr_taps_t taps;

    assign s_ready = !m_valid_q || m_ready;
    assign accept  = s_valid && s_ready;

    // A start-of-frame pixel is placed at (0,0) no matter where the counters stand.
    assign col_cur  = s_sof ? '0 : col_q;
    assign row_cur  = s_sof ? '0 : row_q;
    assign run_base = s_sof ? '0 : run_q;

    hyst_line_buf #(
        .IMG_W (IMG_W)
    ) u_line_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (accept),
        .col    (col_cur),
        .wr_bit (keep),
        .taps   (taps)
    );

    always_comb begin
        first_col = (col_cur == '0);
        last_col  = (col_cur == CW'(IMG_W - 1));
        first_row = (row_cur == '0);
        last_row  = (row_cur == RW'(IMG_H - 1));
        nb_left   = !first_col && left_q;
        nb_up     = !first_row && taps.up;
        nb_ul     = !first_row && !first_col && taps.ul;
        nb_ur     = !first_row && !last_col && taps.ur;
        conn      = nb_left || nb_up || ((CONNECT8 != 0) && (nb_ul || nb_ur));
        keep      = (s_edge == EDGE_STRONG) || ((s_edge == EDGE_WEAK) && conn);
    end

    // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        run_d         = run_q;
        frame_edges_d = frame_edges_q;
        frame_done_d  = 1'b0;
        left_d        = left_q;
        m_valid_d     = m_valid_q;
        m_pixel_d     = m_pixel_q;
        m_eol_d       = m_eol_q;
        m_eof_d       = m_eof_q;

        if (accept) begin
            m_valid_d = 1'b1;
            m_pixel_d = keep ? '1 : '0;
            m_eol_d   = last_col;
            m_eof_d   = last_col && last_row;
            left_d    = keep;
            col_d     = last_col ? '0 : col_cur + CW'(1);
            row_d     = last_col ? (last_row ? '0 : row_cur + RW'(1)) : row_cur;
            if (last_col && last_row) begin
                frame_edges_d = run_base + NW'(keep);
                frame_done_d  = 1'b1;
                run_d         = '0;
            end else begin
                run_d = run_base + NW'(keep);
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            run_q         <= '0;
            frame_edges_q <= '0;
            frame_done_q  <= 1'b0;
            left_q        <= 1'b0;
            m_valid_q     <= 1'b0;
            m_pixel_q     <= '0;
            m_eol_q       <= 1'b0;
            m_eof_q       <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            run_q         <= run_d;
            frame_edges_q <= frame_edges_d;
            frame_done_q  <= frame_done_d;
            left_q        <= left_d;
            m_valid_q     <= m_valid_d;
            m_pixel_q     <= m_pixel_d;
            m_eol_q       <= m_eol_d;
            m_eof_q       <= m_eof_d;
        end
    end

    assign m_valid     = m_valid_q;
    assign m_pixel     = m_pixel_q;
    assign m_eol       = m_eol_q;
    assign m_eof       = m_eof_q;
    assign frame_edges = frame_edges_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_hysteresis_tracker_stream.sv
// Bench: two trackers (8-connected and 4-connected) share one input stream and are
// compared against a per-frame keep-map model of the hysteresis rules.
module tb_hysteresis_tracker_stream;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int OW = 8;
    localparam int NW = $clog2(W * H + 1);

    localparam logic [1:0] E_NONE   = 2'b00;
    localparam logic [1:0] E_WEAK   = 2'b01;
    localparam logic [1:0] E_STRONG = 2'b10;
    localparam logic [1:0] E_RSVD   = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst     = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_sof   = 1'b0;
    logic [1:0] s_edge  = 2'b00;
    logic       m_ready = 1'b1;

    // Index 0: CONNECT8=1, index 1: CONNECT8=0.
    logic [1:0]    s_ready_o, m_valid_o, m_eol_o, m_eof_o, frame_done_o;
    logic [OW-1:0] m_pixel_o     [2];
    logic [NW-1:0] frame_edges_o [2];

    hysteresis_tracker_stream #(.IMG_W(W), .IMG_H(H), .OUT_W(OW), .CONNECT8(1)) dut8 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_o[0]), .s_sof(s_sof),
        .s_edge(s_edge), .m_valid(m_valid_o[0]), .m_ready(m_ready), .m_pixel(m_pixel_o[0]),
        .m_eol(m_eol_o[0]), .m_eof(m_eof_o[0]), .frame_edges(frame_edges_o[0]),
        .frame_done(frame_done_o[0])
    );

    hysteresis_tracker_stream #(.IMG_W(W), .IMG_H(H), .OUT_W(OW), .CONNECT8(0)) dut4 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready_o[1]), .s_sof(s_sof),
        .s_edge(s_edge), .m_valid(m_valid_o[1]), .m_ready(m_ready), .m_pixel(m_pixel_o[1]),
        .m_eol(m_eol_o[1]), .m_eof(m_eof_o[1]), .frame_edges(frame_edges_o[1]),
        .frame_done(frame_done_o[1])
    );

    typedef struct {
        logic [OW-1:0] pix;
        logic          eol;
        logic          eof;
    } out_t;

    int   checks   = 0;
    int   failures = 0;

    // Reference model state.
    bit   km [2][H][W];
    int   pos_r, pos_c;
    int   run_cnt [2];
    out_t exp_q [2][$];
    int   exp_fe [2][$];
    bit   stalled [2];
    out_t held [2];

    function automatic bit model_keep(int m, int r, int c, logic [1:0] e);
        bit conn;
        conn = 1'b0;
        if (c > 0 && km[m][r][c-1]) conn = 1'b1;
        if (r > 0) begin
            if (km[m][r-1][c]) conn = 1'b1;
            if (m == 0) begin
                if (c > 0 && km[m][r-1][c-1]) conn = 1'b1;
                if (c < W - 1 && km[m][r-1][c+1]) conn = 1'b1;
            end
        end
        return (e == E_STRONG) || ((e == E_WEAK) && conn);
    endfunction

    task automatic model_accept(input logic [1:0] e, input bit sof);
        out_t o;
        bit   k;
        if (sof) begin
            pos_r = 0;
            pos_c = 0;
            run_cnt[0] = 0;
            run_cnt[1] = 0;
        end
        for (int m = 0; m < 2; m++) begin
            k = model_keep(m, pos_r, pos_c, e);
            km[m][pos_r][pos_c] = k;
            o.pix = k ? {OW{1'b1}} : '0;
            o.eol = (pos_c == W - 1);
            o.eof = o.eol && (pos_r == H - 1);
            exp_q[m].push_back(o);
            if (o.eof) begin
                exp_fe[m].push_back(run_cnt[m] + int'(k));
                run_cnt[m] = 0;
            end else begin
                run_cnt[m] += int'(k);
            end
        end
        pos_c++;
        if (pos_c == W) begin
            pos_c = 0;
            pos_r = (pos_r + 1) % H;
        end
    endtask

    task automatic model_clear();
        pos_r = 0;
        pos_c = 0;
        for (int m = 0; m < 2; m++) begin
            run_cnt[m] = 0;
            exp_q[m].delete();
            exp_fe[m].delete();
            stalled[m] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check pre-edge handshake/stream, clock, check frame_done.
    task automatic step(input bit v, input logic [1:0] e, input bit sof, input bit mr, output bit acc);
        out_t o;
        s_valid = v;
        s_edge  = e;
        s_sof   = sof;
        m_ready = mr;
        #1;
        for (int m = 0; m < 2; m++) begin
            if (stalled[m]) begin
                checks++;
                if (m_valid_o[m] !== 1'b1 || m_pixel_o[m] !== held[m].pix ||
                    m_eol_o[m] !== held[m].eol || m_eof_o[m] !== held[m].eof) begin
                    failures++;
                    $display("FAIL stall_hold dut%0d: got v=%b pix=%h eol=%b eof=%b, need v=1 pix=%h eol=%b eof=%b",
                             m, m_valid_o[m], m_pixel_o[m], m_eol_o[m], m_eof_o[m],
                             held[m].pix, held[m].eol, held[m].eof);
                end
            end
            checks++;
            if (s_ready_o[m] !== (!m_valid_o[m] || mr)) begin
                failures++;
                $display("FAIL s_ready dut%0d: got %b, need %b", m, s_ready_o[m], !m_valid_o[m] || mr);
            end
            if (m_valid_o[m] === 1'b1 && mr) begin
                checks++;
                if (exp_q[m].size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output dut%0d: got pix=%h with nothing pending", m, m_pixel_o[m]);
                end else begin
                    o = exp_q[m].pop_front();
                    if (m_pixel_o[m] !== o.pix || m_eol_o[m] !== o.eol || m_eof_o[m] !== o.eof) begin
                        failures++;
                        $display("FAIL out_stream dut%0d: got pix=%h eol=%b eof=%b, need pix=%h eol=%b eof=%b",
                                 m, m_pixel_o[m], m_eol_o[m], m_eof_o[m], o.pix, o.eol, o.eof);
                    end
                end
            end
            stalled[m] = (m_valid_o[m] === 1'b1) && !mr;
            held[m].pix = m_pixel_o[m];
            held[m].eol = m_eol_o[m];
            held[m].eof = m_eof_o[m];
        end
        acc = v && (s_ready_o[0] === 1'b1);
        if (acc) model_accept(e, sof);
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            if (frame_done_o[m] === 1'b1) begin
                checks++;
                if (exp_fe[m].size() == 0) begin
                    failures++;
                    $display("FAIL spurious_frame_done dut%0d: got frame_edges=%0d, no frame completed", m, frame_edges_o[m]);
                end else begin
                    int fe;
                    fe = exp_fe[m].pop_front();
                    if (frame_edges_o[m] !== NW'(fe)) begin
                        failures++;
                        $display("FAIL frame_edges dut%0d: got %0d, need %0d", m, frame_edges_o[m], fe);
                    end
                end
            end
        end
    endtask

    // Offer one pixel until it is accepted, with optional input gaps and random m_ready.
    task automatic send(input logic [1:0] e, input bit sof, input int gap_pct, input bit rand_rdy);
        bit acc;
        bit v;
        bit mr;
        for (int t = 0; t < 200; t++) begin
            v  = ($urandom_range(0, 99) >= gap_pct);
            mr = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            step(v, e, sof, mr, acc);
            if (acc) return;
        end
        checks++;
        failures++;
        $display("FAIL accept_timeout: pixel not accepted within 200 cycles");
    endtask

    task automatic drain();
        bit acc;
        for (int t = 0; t < 4; t++) step(1'b0, E_NONE, 1'b0, 1'b1, acc);
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (exp_q[m].size() != 0 || exp_fe[m].size() != 0) begin
                failures++;
                $display("FAIL drain dut%0d: got %0d pixels and %0d frame_done pending, need 0 and 0",
                         m, exp_q[m].size(), exp_fe[m].size());
            end
        end
    endtask

    function automatic logic [1:0] rand_edge();
        int r;
        r = $urandom_range(0, 9);
        if (r < 2) return E_STRONG;
        if (r < 6) return E_WEAK;
        if (r == 6) return E_RSVD;
        return E_NONE;
    endfunction

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (m_valid_o[m] !== 1'b0 || m_pixel_o[m] !== '0 || m_eol_o[m] !== 1'b0 ||
                m_eof_o[m] !== 1'b0 || frame_edges_o[m] !== '0 || frame_done_o[m] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: got v=%b pix=%h eol=%b eof=%b fe=%0d done=%b, need all zero",
                         m, m_valid_o[m], m_pixel_o[m], m_eol_o[m], m_eof_o[m], frame_edges_o[m], frame_done_o[m]);
            end
        end
    endtask

    task automatic check_fe(input string name, input int m, input int need);
        checks++;
        if (frame_edges_o[m] !== NW'(need)) begin
            failures++;
            $display("FAIL %s dut%0d: got frame_edges=%0d, need %0d", name, m, frame_edges_o[m], need);
        end
    endtask

    task automatic test_all_strong();
        for (int i = 0; i < W * H; i++) send(E_STRONG, i == 0, 0, 1'b0);
        drain();
        check_fe("all_strong_count", 0, W * H);
        check_fe("all_strong_count", 1, W * H);
    endtask

    task automatic test_connectivity();
        logic [1:0] e;
        for (int i = 0; i < W * H; i++) begin
            e = E_NONE;
            if (i == 3) e = E_STRONG;
            if (i == W + 4) e = E_WEAK;
            send(e, i == 0, 0, 1'b0);
        end
        drain();
        check_fe("diag_connect8", 0, 2);
        check_fe("diag_connect4", 1, 1);
    endtask

    task automatic test_no_wrap();
        logic [1:0] e;
        // Strong at (0,7), weak at (1,0).
        for (int i = 0; i < W * H; i++) begin
            e = (i == W - 1) ? E_STRONG : (i == W) ? E_WEAK : E_NONE;
            send(e, i == 0, 0, 1'b0);
        end
        drain();
        check_fe("no_left_wrap", 0, 1);
        check_fe("no_left_wrap", 1, 1);
        // Strong at (0,0), weak at (1,7).
        for (int i = 0; i < W * H; i++) begin
            e = (i == 0) ? E_STRONG : (i == 2 * W - 1) ? E_WEAK : E_NONE;
            send(e, i == 0, 0, 1'b0);
        end
        drain();
        check_fe("no_upright_wrap", 0, 1);
        check_fe("no_upright_wrap", 1, 1);
    endtask

    task automatic test_random_backpressure();
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < W * H; i++) send(rand_edge(), (i == 0) && (f != 2), 30, 1'b1);
        drain();
    endtask

    task automatic test_sof_abort();
        int done_seen;
        for (int i = 0; i < 13; i++) send(rand_edge(), i == 0, 30, 1'b1);
        for (int i = 0; i < W * H; i++) send(rand_edge(), i == 0, 30, 1'b1);
        drain();
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 2 * W + 3; i++) send(rand_edge(), i == 0, 30, 1'b1);
        test_reset();
        for (int i = 0; i < W * H; i++) send(rand_edge(), 1'b0, 30, 1'b1);
        drain();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_all_strong();
        test_connectivity();
        test_no_wrap();
        test_random_backpressure();
        test_sof_abort();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
